// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO and its burst reader.
// Pure declarations: no logic, no latency.
// No flow control lives here.
package fifo_pkg;

  // Burst reader control states.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Bits needed to hold the value n (never less than one bit).
  function automatic int bits(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_rd_m_if.sv
// FIFO read-side plus burst stream bundle seen by the burst reader.
// Wires only, no latency.
// Stream side is valid/ready; the FIFO side is FWFT with a combinational pop.
interface fifo_burst_rd_m_if
  import fifo_pkg::*;
#(
  parameter type DATA_ITEM_TYPE = logic,
  parameter int  DEPTH          = 32
) ();

  localparam int DATA_COUNT_W = bits(DEPTH);

  // FIFO read side
  DATA_ITEM_TYPE           head;
  logic                    empty;
  logic [DATA_COUNT_W-1:0] data_count;
  logic                    rd_rst_busy;
  logic                    pop;

  // Burst stream side
  DATA_ITEM_TYPE           m_data;
  logic                    m_valid;
  logic                    m_last;
  logic                    m_ready;

  // The burst reader
  modport master (
    input  head, empty, data_count, rd_rst_busy, m_ready,
    output pop, m_data, m_valid, m_last
  );

  // FIFO plus stream consumer, seen from the other side
  modport slave (
    output head, empty, data_count, rd_rst_busy, m_ready,
    input  pop, m_data, m_valid, m_last
  );

endinterface

// File: rtl/fifo_sc_c_m.sv
// Single-clock first-word-fall-through FIFO with a read data count.
// Write visible at head/count one cycle after wr_en; pop takes effect at the clock edge.
// Writes while full and reads while empty are ignored.
module fifo_sc_c_m
  import fifo_pkg::*;
#(
  parameter type DATA_ITEM_TYPE = logic,
  parameter int  DEPTH          = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  DATA_ITEM_TYPE            wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output DATA_ITEM_TYPE            head,
  output logic                     empty,
  output logic [bits(DEPTH)-1:0]   data_count
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CW = bits(DEPTH);

  DATA_ITEM_TYPE   mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            do_wr;
  logic            do_rd;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head       = mem[rptr];
  assign data_count = count;
  assign do_wr      = wr_en && !full;
  assign do_rd      = rd_en && !empty;

  // Storage array; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping with wrap at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
      if (do_rd) rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/fifo_burst_rd_m.sv
// Drains an FWFT FIFO in bursts (full, timeout-forced or flushed) onto a valid/ready stream.
// Trigger seen at N -> first pop at N+1 -> first m_valid at N+2; then one beat per cycle.
// Outputs hold while m_valid && !m_ready; no pop is issued until the held beat is taken.
module fifo_burst_rd_m
  import fifo_pkg::*;
#(
  parameter type DATA_ITEM_TYPE = logic,
  parameter int  DEPTH          = 32,
  parameter int  BURST_LEN      = 8,
  parameter int  TIMEOUT        = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_burst_rd_m_if.master    bus,
  input  logic                 flush,
  output logic                 busy
);

  localparam int DATA_COUNT_W = bits(DEPTH);
  localparam int REM_W        = bits(BURST_LEN);
  localparam int TMR_W        = bits(TIMEOUT);
  localparam logic [DATA_COUNT_W-1:0] BURST_LEN_C = DATA_COUNT_W'(BURST_LEN);

  state_t                   state;
  logic [REM_W-1:0]         remaining;
  logic [TMR_W-1:0]         timer;
  DATA_ITEM_TYPE            data_q;
  logic                     valid_q;
  logic                     last_q;
  logic [DATA_COUNT_W-1:0]  short_len;
  logic                     timer_hit;
  logic                     pop_c;
  logic                     accept;

  assign timer_hit = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1));
  assign accept    = valid_q && bus.m_ready;
  assign pop_c     = (state == BURST) && (remaining != '0) && !bus.empty &&
                     !bus.rd_rst_busy && (!valid_q || bus.m_ready);

  assign bus.pop     = pop_c;
  assign bus.m_data  = data_q;
  assign bus.m_valid = valid_q;
  assign bus.m_last  = last_q;

  // Partial burst length: min(data_count, BURST_LEN) at count width, at least one beat
  // because a non-empty FIFO may briefly report a zero count.
  always_comb begin
    short_len = BURST_LEN_C;
    if (bus.data_count < BURST_LEN_C) short_len = bus.data_count;
    if (short_len == '0) short_len = DATA_COUNT_W'(1);
  end

  // Burst control FSM with the registered stream output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      remaining <= '0;
      timer     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rd_rst_busy) begin
            timer <= '0;
          end else if (bus.empty) begin
            timer <= '0;
          end else if (bus.data_count >= BURST_LEN_C) begin
            state     <= BURST;
            busy      <= 1'b1;
            remaining <= REM_W'(BURST_LEN);
            timer     <= '0;
          end else if (flush || timer_hit) begin
            state     <= BURST;
            busy      <= 1'b1;
            remaining <= REM_W'(short_len);
            timer     <= '0;
          end else if (TIMEOUT != 0) begin
            // timer_hit is taken above, so the count tops out at TIMEOUT-1.
            timer <= timer + TMR_W'(1);
          end
        end
        BURST: begin
          if (pop_c) begin
            data_q    <= bus.head;
            valid_q   <= 1'b1;
            last_q    <= (remaining == REM_W'(1));
            remaining <= remaining - REM_W'(1);
          end else if (accept) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
          if (accept && last_q) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_rd_m.sv
// Bench: FIFO + burst reader, random item data checked against a queue model of the stream.
// Directed steps in one initial block; a negedge monitor records accepted beats and invariants.
// Expected burst shapes come from the burst rules, not from the DUT state.
module tb_fifo_burst_rd_m;
  import fifo_pkg::*;

  localparam int DEPTH     = 32;
  localparam int BURST_LEN = 8;
  localparam int TIMEOUT   = 64;
  typedef logic [15:0] item_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  flush = 1'b0;
  logic  busy;
  logic  wr_en = 1'b0;
  logic  full;
  item_t wr_data = '0;
  logic  rrb = 1'b0;
  logic  rdy = 1'b1;

  always #5 clk = ~clk;

  fifo_burst_rd_m_if #(.DATA_ITEM_TYPE(item_t), .DEPTH(DEPTH)) bus ();
  assign bus.rd_rst_busy = rrb;
  assign bus.m_ready     = rdy;

  fifo_sc_c_m #(.DATA_ITEM_TYPE(item_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(bus.pop), .head(bus.head), .empty(bus.empty), .data_count(bus.data_count)
  );

  fifo_burst_rd_m #(.DATA_ITEM_TYPE(item_t), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN),
                    .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .flush(flush), .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  item_t       exp_q[$];
  logic [16:0] got_q[$];
  int          lens_q[$];
  int          gap_q[$];
  int  cyc = 0, viol = 0, last_acc = -1;
  int  arm = 0, t_ne = -1, t_pop = -1;
  logic  prev_stall = 1'b0, prev_last = 1'b0;
  item_t prev_dat = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr_data = item_t'($urandom);
      wr_en   = 1'b1;
      exp_q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
  endtask

  // mode 0: ready held at 1; mode 1: ready pattern 1,0,0,1 repeating
  task automatic drain(input int n, input int mode, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      if (mode == 1) rdy = (k % 4 == 0) || (k % 4 == 3);
      step();
      k++;
    end
    rdy = 1'b1;
    repeat (4) step();
  endtask

  task automatic check_stream(input string tag);
    int n, cum, li;
    logic el;
    n = exp_q.size();
    check({tag, " beats"}, got_q.size(), n);
    cum = (lens_q.size() > 0) ? lens_q[0] : 0;
    li  = 0;
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      el = (i + 1 == cum);
      if (el) begin
        li++;
        if (li < lens_q.size()) cum += lens_q[li];
      end
      check({tag, " data"}, got_q[i][15:0], exp_q[i]);
      check({tag, " last"}, got_q[i][16], el);
    end
    got_q.delete();
    exp_q.delete();
    lens_q.delete();
  endtask

  // Monitor: accepted beats, stall stability, illegal pops, burst gaps.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.pop && bus.m_valid && !bus.m_ready) viol++;
        if (bus.pop && (bus.empty || bus.rd_rst_busy)) viol++;
        if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_dat ||
                           bus.m_last !== prev_last)) viol++;
        if (bus.pop && last_acc >= 0) begin
          gap_q.push_back(cyc - last_acc);
          last_acc = -1;
        end
        if (arm != 0 && !bus.empty && t_ne < 0) t_ne = cyc;
        if (arm != 0 && bus.pop && t_pop < 0) t_pop = cyc;
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_dat   = bus.m_data;
        prev_last  = bus.m_last;
        if (bus.m_valid && bus.m_ready) begin
          got_q.push_back({bus.m_last, bus.m_data});
          if (bus.m_last) last_acc = cyc;
        end
      end
    end
  end

  initial begin
    int k, bad, n, pushed, run, maxrun;

    // Reset values
    repeat (3) step();
    check("rst m_valid", bus.m_valid, 0);
    check("rst m_last", bus.m_last, 0);
    check("rst m_data", bus.m_data, 0);
    check("rst busy", busy, 0);
    check("rst pop", bus.pop, 0);
    rst = 1'b0;
    step();

    // Full burst of 8: latency 2 from count reaching 8
    push_n(8);
    k = 0;
    while (!bus.m_valid && k < 20) begin
      step();
      k++;
    end
    check("t1 first valid latency", k, 2);
    lens_q.push_back(8);
    drain(8, 0, 100);
    check_stream("t1");

    // Three items: burst forced by timeout on the 64th non-empty idle cycle
    arm = 1; t_ne = -1; t_pop = -1;
    push_n(3);
    drain(3, 0, 200);
    arm = 0;
    check("t2 timeout first pop", t_pop - t_ne, TIMEOUT);
    lens_q.push_back(3);
    check_stream("t2");

    // Twenty items: 8, 8, then 4 via timeout; one idle cycle between full bursts
    gap_q.delete();
    last_acc = -1;
    push_n(20);
    drain(20, 0, 300);
    check("t3 burst gap", (gap_q.size() > 0) ? gap_q[0] : -1, 2);
    lens_q.push_back(8); lens_q.push_back(8); lens_q.push_back(4);
    check_stream("t3");

    // Backpressure: ready 1,0,0,1,...
    rdy = 1'b0;
    push_n(8);
    drain(8, 1, 200);
    lens_q.push_back(8);
    check_stream("t4");
    check("t4 stall invariants", viol, 0);

    // Flush with two items queued, then flush with an empty FIFO
    push_n(2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5 pop after flush", bus.pop, 1);
    check("t5 busy after flush", busy, 1);
    drain(2, 0, 50);
    lens_q.push_back(2);
    check_stream("t5");
    flush = 1'b1;
    bad = 0;
    repeat (10) begin
      step();
      if (bus.pop || busy || bus.m_valid) bad++;
    end
    flush = 1'b0;
    check("t5 empty flush activity", bad, 0);
    check("t5 empty flush beats", got_q.size(), 0);

    // Reset mid-burst after beat 3, then rd_rst_busy holds the block idle
    push_n(8);
    k = 0;
    while (got_q.size() < 3 && k < 50) begin
      step();
      k++;
    end
    rst = 1'b1;
    #1;
    check("t6 rst m_valid", bus.m_valid, 0);
    check("t6 rst m_last", bus.m_last, 0);
    check("t6 rst m_data", bus.m_data, 0);
    check("t6 rst busy", busy, 0);
    check("t6 beats before rst", got_q.size(), 3);
    got_q.delete();
    exp_q.delete();
    rrb = 1'b1;
    step();
    rst = 1'b0;
    push_n(9);
    bad = 0;
    repeat (20) begin
      step();
      if (bus.pop || busy) bad++;
    end
    check("t6 rd_rst_busy idle", bad, 0);
    check("t6 rd_rst_busy beats", got_q.size(), 0);
    rrb = 1'b0;
    drain(9, 0, 200);
    lens_q.push_back(8); lens_q.push_back(1);
    check_stream("t6");

    // Random pushes and random ready: order, count and burst framing
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(12, 40);
      pushed = 0;
      k = 0;
      while ((pushed < n || got_q.size() < n) && k < 3000) begin
        if (pushed < n && bus.data_count < DEPTH - 1 && $urandom_range(0, 1) == 1) begin
          wr_data = item_t'($urandom);
          wr_en   = 1'b1;
          exp_q.push_back(wr_data);
          pushed++;
        end else begin
          wr_en = 1'b0;
        end
        rdy = ($urandom_range(0, 3) != 0);
        step();
        k++;
      end
      wr_en = 1'b0;
      rdy = 1'b1;
      repeat (4) step();
      check("rand beats", got_q.size(), n);
      run = 0;
      maxrun = 0;
      for (int i = 0; i < n && i < got_q.size(); i++) begin
        check("rand data", got_q[i][15:0], exp_q[i]);
        run++;
        if (got_q[i][16]) begin
          if (run > maxrun) maxrun = run;
          run = 0;
        end
      end
      check("rand burst len bound", (maxrun <= BURST_LEN && maxrun > 0), 1);
      check("rand final last", run, 0);
      got_q.delete();
      exp_q.delete();
    end

    check("invariants", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
